pipe_stage_fifo: RTL and testbench
==================================

// Module: pipe_stage_fifo
// PURPOSE
//  Parametrised decode->execute pipeline buffer; next generation of the single-entry ID/EX latch.
//  Holds up to DEPTH decoded ops (op, rs1, rs2, rd, imm, pc) in a circular queue.
//  Valid/ready on both sides, a flush for branch mispredicts, and a global rdy freeze.
//  Lets ID run ahead of a multi-cycle EX without stalling on every op.
// PARAMETERS
//  DEPTH     2                entries, power of 2, >=2
//  OP_W      32               width of op field; op==`EX_NOP means bubble
//  RD_W      `LOG_REG_CNT     destination register id width
//  PAYLOAD_W OP_W+4*32+RD_W   packed entry width {op,rs1,rs2,imm,pc,rd}
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous, active-low reset
//  rdy        in   1          global enable; 0 freezes all state
//  flush      in   1          discard every entry (redirect)
//  in_valid   in   1          ID presents an op
//  in_ready   out  1          buffer accepts this cycle
//  in_payload in   PAYLOAD_W  packed decoded op
//  out_valid  out  1          head entry valid to EX
//  out_ready  in   1          EX consumes head this cycle
//  out_payload out PAYLOAD_W  head entry; op field forced to `EX_NOP when !out_valid
//  count      out  $clog2(DEPTH)+1 occupancy
// BEHAVIOUR
//  - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0, out_valid=0, out_payload op=`EX_NOP,
//    in_ready=1. Storage contents not reset. Reset mid-transfer drops all entries.
//  - rdy=0: no pointer, count or storage update; outputs hold; handshakes ignored.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both sampled at posedge.
//  - in_ready = (count < DEPTH), registered-state-derived only; no comb path from out_ready.
//  - out_valid = (count != 0); out_payload is registered storage at rd_ptr (no comb bypass).
//  - Latency: op pushed at edge N is visible on out_* after edge N (first cycle out_valid).
//  - Empty: push only -> count 1. Push+pop impossible when empty (out_valid=0).
//  - Full: in_ready=0; push ignored. Pop when full -> in_ready=1 next cycle, not same cycle.
//  - Simultaneous push+pop (0<count<DEPTH): both pointers advance, count unchanged.
//  - Pointers wrap modulo DEPTH; count saturates neither way (overflow/underflow impossible;
//    assertion fires if count>DEPTH).
//  - flush=1 (and rdy=1): next cycle count=0, rd_ptr=wr_ptr, out_valid=0; same-cycle push and
//    pop are discarded (flush has priority). flush with rdy=0 is ignored.
//  - Ops with op==`EX_NOP and in_valid=1 are accepted and forwarded unchanged (bubble slots).
// STRUCTURE
//  - const.v gains `PIPE_DEPTH, field offsets `PL_OP_LSB, `PL_RS1_LSB, `PL_RS2_LSB,
//    `PL_IMM_LSB, `PL_PC_LSB, `PL_RD_LSB for pack/unpack shared by ID and EX.
//  - One sub-module: pipe_fifo_mem (DEPTH x PAYLOAD_W register array, 1 write port,
//    1 async read port). Pointer/count/flush control stays in pipe_stage_fifo.
//  - Existing `EX_NOP and `LOG_REG_CNT reused unchanged.
// TESTING
//  1. Reset: hold rst_n=0 mid-run with count=2 -> out_valid=0, op=`EX_NOP, count=0, in_ready=1.
//  2. Fill: out_ready=0, push ops pc=0x00,0x04,0x08 (DEPTH=2) -> third refused, count=2,
//     head pc=0x00; then out_ready=1 -> pops 0x00,0x04 in order, in_ready=1 one cycle after pop.
//  3. Streaming: in_valid=out_ready=1 for 10 cycles, pc 0x10..0x34 -> count stays 1,
//     every pc delivered in order, one per cycle.
//  4. Flush: count=2, assert flush with in_valid=1 (pc=0x40) -> next cycle count=0,
//     out_valid=0, pc 0x40 never appears on output.
//  5. Freeze: count=1, rdy=0 with in_valid=out_ready=flush=1 for 3 cycles -> count, outputs
//     unchanged; rdy=1 resumes with original head.
//  6. Wrap: DEPTH=4, 9 push/pop cycles with random out_ready -> scoreboard order, no loss.

Source files
------------

// File: rtl/pipe_stage_fifo_pkg.sv
// Shared decode->execute constants: bubble opcode, register id width and the
// packed payload layout {op,rs1,rs2,imm,pc,rd} used by both ID and EX.
package pipe_stage_fifo_pkg;

  localparam int LOG_REG_CNT = 5;
  localparam int PIPE_DEPTH  = 2;
  localparam int XLEN        = 32;

  // addi x0,x0,0 -- the canonical bubble
  localparam logic [31:0] EX_NOP = 32'h0000_0013;

  localparam int PL_RD_LSB  = 0;
  localparam int PL_PC_LSB  = PL_RD_LSB  + LOG_REG_CNT;
  localparam int PL_IMM_LSB = PL_PC_LSB  + XLEN;
  localparam int PL_RS2_LSB = PL_IMM_LSB + XLEN;
  localparam int PL_RS1_LSB = PL_RS2_LSB + XLEN;
  localparam int PL_OP_LSB  = PL_RS1_LSB + XLEN;
  localparam int PAYLOAD_W  = PL_OP_LSB  + 32;

  typedef struct packed {
    logic [31:0]            op;
    logic [XLEN-1:0]        rs1;
    logic [XLEN-1:0]        rs2;
    logic [XLEN-1:0]        imm;
    logic [XLEN-1:0]        pc;
    logic [LOG_REG_CNT-1:0] rd;
  } dec_op_t;

  function automatic logic [PAYLOAD_W-1:0] pack_op(dec_op_t d);
    return PAYLOAD_W'(d);
  endfunction

  function automatic dec_op_t unpack_op(logic [PAYLOAD_W-1:0] p);
    return dec_op_t'(p);
  endfunction

endpackage

// File: rtl/pipe_fifo_mem.sv
// DEPTH x W register array: one synchronous write port, one async read port.
// Contents are deliberately not reset; validity is tracked by the controller.
module pipe_fifo_mem #(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [DEPTH-1:0][W-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_stage_fifo.sv
// Decode->execute buffer: DEPTH-entry circular queue with valid/ready on both
// sides, flush for redirects and a global rdy freeze.
module pipe_stage_fifo
  import pipe_stage_fifo_pkg::*;
#(
  parameter int DEPTH     = PIPE_DEPTH,
  parameter int OP_W      = 32,
  parameter int RD_W      = LOG_REG_CNT,
  parameter int PAYLOAD_W = OP_W + 4*32 + RD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rdy,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PAYLOAD_W-1:0]   in_payload,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PAYLOAD_W-1:0]   out_payload,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [PAYLOAD_W-1:0] head;
  logic                 push, pop, upd;

  // Handshake qualifiers depend on registered count only, so in_ready has no
  // combinational path from out_ready.
  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign upd       = rdy & ~flush;

  pipe_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (PAYLOAD_W)
  ) u_mem (
    .clk   (clk),
    .we    (upd & push),
    .waddr (wr_ptr),
    .wdata (in_payload),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rdy) begin
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Stale storage must never look like a real op to EX.
  always_comb begin
    out_payload = head;
    if (!out_valid) out_payload[PAYLOAD_W-1 -: OP_W] = OP_W'(EX_NOP);
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (count <= FULL);
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: DEPTH=2 and DEPTH=4 instances share stimulus and
// are checked every cycle against queue models plus literal expectations.
module tb_pipe_stage_fifo;
  import pipe_stage_fifo_pkg::*;

  localparam int PW     = 165;
  localparam int PC_LSB = 5;
  localparam int OP_LSB = 133;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rdy = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [PW-1:0] in_payload = '0;

  logic          ir2, ov2, ir4, ov4;
  logic [PW-1:0] pl2, pl4;
  logic [1:0]    cnt2;
  logic [2:0]    cnt4;

  int n_chk = 0;
  int n_fail = 0;

  logic [PW-1:0] q2[$];
  logic [PW-1:0] q4[$];
  bit            mp2, mp4;

  always #5 clk = ~clk;

  pipe_stage_fifo #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(ir2), .in_payload(in_payload),
    .out_valid(ov2), .out_ready(out_ready), .out_payload(pl2), .count(cnt2)
  );

  pipe_stage_fifo #(.DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(ir4), .in_payload(in_payload),
    .out_valid(ov4), .out_ready(out_ready), .out_payload(pl4), .count(cnt4)
  );

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue model: a push is accepted when the queue has room before the edge,
  // a pop happens when it is non-empty; flush empties it, rdy=0 freezes it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q2.delete();
      q4.delete();
    end else if (rdy) begin
      if (flush) begin
        q2.delete();
        q4.delete();
      end else begin
        mp2 = in_valid && (q2.size() < 2);
        mp4 = in_valid && (q4.size() < 4);
        if (out_ready && q2.size() != 0) void'(q2.pop_front());
        if (out_ready && q4.size() != 0) void'(q4.pop_front());
        if (mp2) q2.push_back(in_payload);
        if (mp4) q4.push_back(in_payload);
      end
    end
  end

  task automatic cmp(input string tag, input logic ov, input logic ir, input int cnt,
                     input logic [PW-1:0] pl, input int sz, input int depth,
                     input logic [PW-1:0] head);
    check({tag, "_out_valid"}, PW'(ov), PW'(sz != 0));
    check({tag, "_in_ready"},  PW'(ir), PW'(sz < depth));
    check({tag, "_count"},     PW'(cnt), PW'(sz));
    if (sz != 0) check({tag, "_payload"}, pl, head);
    else         check({tag, "_nop_op"}, PW'(pl[OP_LSB +: 32]), PW'(EX_NOP));
  endtask

  always @(negedge clk) begin
    cmp("d2", ov2, ir2, int'(cnt2), pl2, q2.size(), 2, (q2.size() != 0) ? q2[0] : '0);
    cmp("d4", ov4, ir4, int'(cnt4), pl4, q4.size(), 4, (q4.size() != 0) ? q4[0] : '0);
  end

  function automatic logic [PW-1:0] mk(input logic [31:0] pc, input logic [31:0] op);
    logic [4:0] rd;
    rd = 5'($urandom());
    return {op, 32'($urandom()), 32'($urandom()), 32'($urandom()), pc, rd};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // fill DEPTH=2: third push refused, then ordered drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_payload = mk(32'(4 * i), 32'h0000_0033);
      check("fill_in_ready", PW'(ir2), PW'(i < 2));
      cyc();
    end
    in_valid = 1'b0;
    check("fill_count", PW'(cnt2), PW'(2));
    check("fill_head_pc", PW'(pl2[PC_LSB +: 32]), PW'(32'h00));
    check("fill_model_size", PW'(q2.size()), PW'(2));
    out_ready = 1'b1;
    check("full_in_ready_same_cycle", PW'(ir2), PW'(0));
    cyc();
    check("pop1_head_pc", PW'(pl2[PC_LSB +: 32]), PW'(32'h04));
    check("pop1_in_ready", PW'(ir2), PW'(1));
    check("pop1_count", PW'(cnt2), PW'(1));
    cyc();
    check("pop2_empty", PW'(ov2), PW'(0));
    repeat (2) cyc();

    // streaming: one op per cycle, occupancy stays 1
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_payload = mk(32'h10 + 32'(4 * i), 32'($urandom()));
      cyc();
      check("stream_count", PW'(cnt2), PW'(1));
      check("stream_head_pc", PW'(pl2[PC_LSB +: 32]), PW'(32'h10 + 32'(4 * i)));
    end
    in_valid = 1'b0;
    repeat (2) cyc();

    // flush beats a same-cycle push
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_payload = mk(32'h38, 32'h0000_0033);
    cyc();
    in_payload = mk(32'h3c, 32'h0000_0033);
    cyc();
    check("preflush_count", PW'(cnt2), PW'(2));
    flush = 1'b1;
    in_payload = mk(32'h40, 32'h0000_0033);
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", PW'(cnt2), PW'(0));
    check("flush_out_valid", PW'(ov2), PW'(0));
    check("flush_count_d4", PW'(cnt4), PW'(0));
    check("flush_model_size", PW'(q2.size()), PW'(0));
    out_ready = 1'b1;
    repeat (3) begin
      cyc();
      check("postflush_no_0x40_d2", PW'(ov2), PW'(0));
      check("postflush_no_0x40_d4", PW'(ov4), PW'(0));
    end

    // freeze with a bubble at the head
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_payload = mk(32'h50, EX_NOP);
    cyc();
    rdy = 1'b0;
    flush = 1'b1;
    out_ready = 1'b1;
    in_payload = mk(32'h54, 32'h0000_0033);
    repeat (3) begin
      cyc();
      check("freeze_count", PW'(cnt2), PW'(1));
      check("freeze_out_valid", PW'(ov2), PW'(1));
      check("freeze_head_pc", PW'(pl2[PC_LSB +: 32]), PW'(32'h50));
      check("freeze_bubble_op", PW'(pl2[OP_LSB +: 32]), PW'(EX_NOP));
    end
    rdy = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cyc();
    check("resume_head_pc", PW'(pl2[PC_LSB +: 32]), PW'(32'h50));
    out_ready = 1'b1;
    cyc();
    check("resume_pop_count", PW'(cnt2), PW'(0));

    // async reset while holding two entries
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_payload = mk(32'h60, 32'h0000_0033);
    cyc();
    in_payload = mk(32'h64, 32'h0000_0033);
    cyc();
    check("prereset_count", PW'(cnt2), PW'(2));
    rst_n = 1'b0;
    #1;
    check("reset_out_valid", PW'(ov2), PW'(0));
    check("reset_count", PW'(cnt2), PW'(0));
    check("reset_in_ready", PW'(ir2), PW'(1));
    check("reset_op", PW'(pl2[OP_LSB +: 32]), PW'(EX_NOP));
    in_valid = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // random traffic: wraps both depths, occasional flush and freeze
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 24) == 0);
      rdy       = ($urandom_range(0, 9) != 0);
      in_payload = mk(32'($urandom()), ($urandom_range(0, 3) == 0) ? EX_NOP : 32'($urandom()));
      cyc();
    end
    rdy = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) cyc();
    check("drain_count_d4", PW'(cnt4), PW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
